// File: rtl/regfile_port_ctrl_if.sv
// Write-port bundle between the register file controller, the core writeback
// path, the debug write requester and the register file itself.
interface regfile_port_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic          core_stall;

    logic          dbg_wr_req;
    logic [3:0]    dbg_wr_addr;
    logic [DW-1:0] dbg_wr_data;
    logic          dbg_wr_ack;

    logic          init_busy;

    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    // Requester side: core writeback and debug port drive requests, see results.
    modport master (
        output core_we, core_addr, core_data,
        output dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        input  core_stall, dbg_wr_ack, init_busy,
        input  rf_we, rf_addr, rf_data
    );

    // Controller side.
    modport slave (
        input  core_we, core_addr, core_data,
        input  dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        output core_stall, dbg_wr_ack, init_busy,
        output rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Owner of the register file write port. Clears r1..r(NREG-1) after reset,
// then arbitrates between core writeback (default winner) and a debug write
// requester. A starvation counter forces one debug grant after MAX_WAIT
// blocked cycles, stalling the core for that single cycle.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_INIT  | clearing r1..r(NREG-1), one register per cycle, core stalled
//   ST_RUN   | normal arbitration between core writeback and debug writes
module regfile_port_ctrl #(
    parameter int NREG     = 16,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_port_ctrl_if.slave   bus
);

    localparam int            WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [AW-1:0]  init_idx;
    logic [WCW-1:0] wait_cnt;
    logic           dbg_done;

    logic           dbg_pend;
    logic           force_dbg;
    logic           core_grant;
    logic           dbg_grant;
    logic           we_req;
    logic           addr_ok;
    logic [AW-1:0]  gnt_addr;
    logic [DW-1:0]  gnt_data;
    logic           stall;
    logic           busy;

    // Request qualification: a held request that was already served is not pending.
    always_comb begin
        dbg_pend  = bus.dbg_wr_req && !dbg_done;
        force_dbg = dbg_pend && (wait_cnt == WAIT_MAX);
    end

    // Next-state, grant selection and write-port drive.
    always_comb begin
        next_state = state;
        core_grant = 1'b0;
        dbg_grant  = 1'b0;
        we_req     = 1'b0;
        gnt_addr   = '0;
        gnt_data   = '0;
        stall      = 1'b0;
        busy       = 1'b0;

        case (state)
            ST_INIT: begin
                we_req   = 1'b1;
                gnt_addr = init_idx;
                stall    = 1'b1;
                busy     = 1'b1;
                if (init_idx == LAST_IDX) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (force_dbg) begin
                    dbg_grant = 1'b1;
                    stall     = bus.core_we;
                end else if (bus.core_we) begin
                    core_grant = 1'b1;
                end else if (dbg_pend) begin
                    dbg_grant = 1'b1;
                end
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase

        if (dbg_grant) begin
            we_req   = 1'b1;
            gnt_addr = AW'(bus.dbg_wr_addr);
            gnt_data = bus.dbg_wr_data;
        end else if (core_grant) begin
            we_req   = 1'b1;
            gnt_addr = bus.core_addr;
            gnt_data = bus.core_data;
        end

        // r0 is hard-wired zero and addresses past NREG do not exist; the grant
        // still completes so the requester is not left hanging.
        addr_ok = (gnt_addr != '0) && (32'(gnt_addr) < NREG);

        // Reset is asynchronous, so the port must be quiet while it is held,
        // not just from the first edge afterwards.
        if (rst) begin
            we_req    = 1'b0;
            dbg_grant = 1'b0;
            stall     = 1'b1;
            busy      = 1'b1;
        end
    end

    // Output drive to the shared bundle.
    always_comb begin
        bus.rf_we      = we_req && addr_ok;
        bus.rf_addr    = gnt_addr;
        bus.rf_data    = gnt_data;
        bus.core_stall = stall;
        bus.dbg_wr_ack = dbg_grant;
        bus.init_busy  = busy;
    end

    // State register, clear index, one-shot debug flag and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= AW'(1);
            wait_cnt <= '0;
            dbg_done <= 1'b0;
        end else begin
            state <= next_state;

            if (state == ST_INIT) begin
                init_idx <= init_idx + 1'b1;
            end

            if (!bus.dbg_wr_req) begin
                dbg_done <= 1'b0;
            end else if (dbg_grant) begin
                dbg_done <= 1'b1;
            end

            if (dbg_grant || !dbg_pend) begin
                wait_cnt <= '0;
            end else if (core_grant && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
